// File: rtl/ibex_fetch_align_fifo_pkg.sv
// Shared constants and helpers for the fetch-side instruction buffer / realigner.
package ibex_fetch_align_fifo_pkg;

  localparam int unsigned FETCH_DEPTH = 3;
  localparam logic [1:0]  INSTR_LEN32 = 2'b11;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } fifo_entry_t;

  function automatic logic is_compressed(input logic [15:0] half);
    return (half[1:0] != INSTR_LEN32);
  endfunction

endpackage

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch buffer at the IF/ID boundary: stores word-aligned fetch responses and
// presents one aligned (compressed or full) instruction per handshake with its PC.
module ibex_fetch_align_fifo
  import ibex_fetch_align_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic        CK,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] branch_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o,
  output logic        instr_new_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fifo_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      pc_r;
  logic             presented_r;

  fifo_entry_t      w0_s;
  fifo_entry_t      w1_s;
  logic [15:0]      half_s;
  logic             comp_s;
  logic             has_one_s;
  logic             has_two_s;
  logic             valid_s;
  logic [31:0]      rdata_s;
  logic             err_s;
  logic             in_ready_s;
  logic             hs_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      pc_inc_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
  assign w0_s         = mem_r[rd_ptr_r];
  assign w1_s         = mem_r[rd_ptr_nxt_s];
  assign half_s       = pc_r[1] ? w0_s.word[31:16] : w0_s.word[15:0];
  assign comp_s       = is_compressed(half_s);
  assign has_one_s    = (count_r != CNT_W'(0));
  assign has_two_s    = (count_r >= CNT_W'(2));

  // Realign head words into one instruction and decide whether it is complete.
  always_comb begin
    rdata_s = 32'h0000_0000;
    valid_s = 1'b0;
    err_s   = 1'b0;
    if (comp_s) begin
      rdata_s = {16'h0000, half_s};
      valid_s = has_one_s;
      err_s   = w0_s.err;
    end else if (!pc_r[1]) begin
      rdata_s = w0_s.word;
      valid_s = has_one_s;
      err_s   = w0_s.err;
    end else begin
      // A faulting first half is emitted at once so the error is not held up
      // waiting for a second word that may never come.
      rdata_s = {w1_s.word[15:0], half_s};
      valid_s = has_two_s | (has_one_s & w0_s.err);
      err_s   = w0_s.err | (has_two_s & w1_s.err);
    end
  end

  assign in_ready_s = (count_r < CNT_FULL);
  assign hs_s       = valid_s & out_ready_i;
  assign push_s     = in_valid_i & in_ready_s & ~clear_i;
  // A compressed instruction in the low half leaves the upper half still to consume.
  assign pop_s      = hs_s & (pc_r[1] | ~comp_s) & ~clear_i;
  assign pc_inc_s   = comp_s ? 32'd2 : 32'd4;

  assign in_ready_o          = in_ready_s;
  assign out_valid_o         = valid_s;
  assign out_rdata_o         = rdata_s;
  assign out_addr_o          = pc_r;
  assign out_is_compressed_o = valid_s & comp_s;
  assign out_err_o           = valid_s & err_s;
  assign instr_new_o         = valid_s & ~presented_r;

  // Word storage; cleared on reset so idle outputs read as zero.
  always_ff @(posedge CK or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= '{word: in_rdata_i, err: in_err_i};
    end
  end

  // Pointers, occupancy, head PC and first-presentation tracking.
  always_ff @(posedge CK or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      pc_r        <= 32'h0000_0000;
      presented_r <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      pc_r        <= {branch_addr_i[31:1], 1'b0};
      presented_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      if (hs_s) begin
        pc_r        <= pc_r + pc_inc_s;
        presented_r <= 1'b0;
      end else if (valid_s && !out_ready_i) begin
        presented_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed, table-driven bench for ibex_fetch_align_fifo with hand-written
// sequences for stall behaviour and asynchronous reset mid-stream.
module tb_ibex_fetch_align_fifo;

  logic        CK;
  logic        rst_ni;
  logic        clear_i;
  logic [31:0] branch_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_is_compressed_o;
  logic        out_err_o;
  logic        instr_new_o;

  int checks;
  int failures;

  ibex_fetch_align_fifo #(.DEPTH(3)) dut (
    .CK                  (CK),
    .rst_ni              (rst_ni),
    .clear_i             (clear_i),
    .branch_addr_i       (branch_addr_i),
    .in_valid_i          (in_valid_i),
    .in_rdata_i          (in_rdata_i),
    .in_err_i            (in_err_i),
    .in_ready_o          (in_ready_o),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_rdata_o         (out_rdata_o),
    .out_addr_o          (out_addr_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_err_o           (out_err_o),
    .instr_new_o         (instr_new_o)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Row: inputs applied this cycle; expectations are outputs seen before the edge.
  typedef struct {
    logic        clr;
    logic [31:0] baddr;
    logic        iv;
    logic [31:0] idata;
    logic        ierr;
    logic        ordy;
    logic        e_valid;
    logic        e_chk;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
    logic        e_comp;
    logic        e_err;
    logic        e_new;
    logic        e_inrdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr, input logic [31:0] baddr, input logic iv,
                              input logic [31:0] idata, input logic ierr, input logic ordy,
                              input logic e_valid, input logic e_chk, input logic [31:0] e_rdata,
                              input logic [31:0] e_addr, input logic e_comp, input logic e_err,
                              input logic e_new, input logic e_inrdy);
    vec_t v;
    v.clr = clr;       v.baddr = baddr;     v.iv = iv;         v.idata = idata;
    v.ierr = ierr;     v.ordy = ordy;       v.e_valid = e_valid; v.e_chk = e_chk;
    v.e_rdata = e_rdata; v.e_addr = e_addr; v.e_comp = e_comp; v.e_err = e_err;
    v.e_new = e_new;   v.e_inrdy = e_inrdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic clr, input logic [31:0] baddr, input logic iv,
                       input logic [31:0] idata, input logic ierr, input logic ordy);
    clear_i       = clr;
    branch_addr_i = baddr;
    in_valid_i    = iv;
    in_rdata_i    = idata;
    in_err_i      = ierr;
    out_ready_i   = ordy;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_ni   = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge CK);
    #1;
    rst_ni = 1'b1;

    chk("reset valid", {31'h0, out_valid_o}, 32'h0);
    chk("reset new",   {31'h0, instr_new_o}, 32'h0);
    chk("reset addr",  out_addr_o, 32'h0);
    chk("reset err",   {31'h0, out_err_o}, 32'h0);
    chk("reset ready", {31'h0, in_ready_o}, 32'h1);
    chk("reset rdata", out_rdata_o, 32'h0);
    chk("reset comp",  {31'h0, out_is_compressed_o}, 32'h0);

    //            clr   baddr         iv    idata         ierr  ordy   val  chk  rdata         addr          comp err  new  rdy
    // basic aligned uncompressed
    vecs.push_back(mk(1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0000_0013, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b1));
    // two compressed halves in one word
    vecs.push_back(mk(1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0084, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h4501_4501, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,         32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_4501, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_4501, 32'h0000_0102, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b1));
    // misaligned uncompressed spanning two words
    vecs.push_back(mk(1'b1, 32'h0000_0102, 1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0513_0000, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,         32'h0000_0102, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'hFFFF_0000, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,         32'h0000_0102, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0513, 32'h0000_0102, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0106, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h5678_FFFF, 32'h0000_0106, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_1234, 32'h0000_010A, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_010C, 1'b0, 1'b0, 1'b0, 1'b1));
    // fill to DEPTH, refused push during simultaneous pop
    vecs.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_010C, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0000_0013, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0010_0093, 1'b0, 1'b0,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0020_0113, 1'b0, 1'b0,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b1, 1'b1, 32'h0010_0093, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0010_0093, 32'h0000_0204, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0020_0113, 32'h0000_0208, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_020C, 1'b0, 1'b0, 1'b0, 1'b1));
    // clear coincident with push and pop; bit 0 of branch address dropped
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0000_0013, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_020C, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_0301, 1'b1, 32'h1111_1111, 1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_020C, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b1));
    // error on a single misaligned word is emitted without a second word
    vecs.push_back(mk(1'b1, 32'h0000_0402, 1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0013_0000, 1'b1, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0402, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b1, 1'b0, 32'h0,         32'h0000_0402, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b0, 32'h0,         32'h0000_0402, 1'b0, 1'b1, 1'b0, 1'b1));
    // error on the second word of a spanning instruction
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0013_0000, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0406, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0406, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0013, 32'h0000_0406, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0000, 32'h0000_040A, 1'b1, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_040C, 1'b0, 1'b0, 1'b0, 1'b1));
    // PC wraps past 2^32
    vecs.push_back(mk(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_040C, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 32'h0001_0000, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].baddr, vecs[i].iv, vecs[i].idata, vecs[i].ierr, vecs[i].ordy);
      chk($sformatf("r%0d valid", i), {31'h0, out_valid_o}, {31'h0, vecs[i].e_valid});
      chk($sformatf("r%0d addr", i),  out_addr_o, vecs[i].e_addr);
      chk($sformatf("r%0d comp", i),  {31'h0, out_is_compressed_o}, {31'h0, vecs[i].e_comp});
      chk($sformatf("r%0d err", i),   {31'h0, out_err_o}, {31'h0, vecs[i].e_err});
      chk($sformatf("r%0d new", i),   {31'h0, instr_new_o}, {31'h0, vecs[i].e_new});
      chk($sformatf("r%0d ready", i), {31'h0, in_ready_o}, {31'h0, vecs[i].e_inrdy});
      if (vecs[i].e_chk) begin
        chk($sformatf("r%0d rdata", i), out_rdata_o, vecs[i].e_rdata);
      end
      tick();
    end

    // Stall for three cycles while pushes continue, then accept.
    drive(1'b1, 32'h0000_0600, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, (k < 2), (k == 0) ? 32'h0000_0093 : 32'h0000_0033, 1'b0, 1'b0);
      chk($sformatf("stall%0d valid", k), {31'h0, out_valid_o}, 32'h1);
      chk($sformatf("stall%0d new", k),   {31'h0, instr_new_o}, (k == 0) ? 32'h1 : 32'h0);
      chk($sformatf("stall%0d rdata", k), out_rdata_o, 32'h0000_0013);
      chk($sformatf("stall%0d addr", k),  out_addr_o, 32'h0000_0600);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("accept new",   {31'h0, instr_new_o}, 32'h0);
    chk("accept rdata", out_rdata_o, 32'h0000_0013);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("next rdata", out_rdata_o, 32'h0000_0093);
    chk("next addr",  out_addr_o, 32'h0000_0604);
    chk("next new",   {31'h0, instr_new_o}, 32'h1);

    // Asynchronous reset between edges drops everything at once.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("areset valid", {31'h0, out_valid_o}, 32'h0);
    chk("areset addr",  out_addr_o, 32'h0);
    chk("areset new",   {31'h0, instr_new_o}, 32'h0);
    chk("areset ready", {31'h0, in_ready_o}, 32'h1);
    chk("areset rdata", out_rdata_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post reset valid", {31'h0, out_valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
